mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mc_pkg.sv | 18 +
 rtl/mc_prio_sel.sv | 36 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the memory arbiter slice.
// Holds the arbiter state encoding, the default address width,
// the default starvation limit, and the starvation counter width helper.
package mc_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } mc_state_e;

    localparam int ADDR_W_DEF     = 18;
    localparam int STARVE_LIM_DEF = 3;

    // Wide enough to hold 0..lim, and never zero bits wide (lim=0 stays legal).
    function automatic int starve_w(input int lim);
        return $clog2(lim + 2);
    endfunction
endpackage

// File: rtl/mc_prio_sel.sv
// mc_prio_sel: fetch/data priority selection with starvation override.
// Ports:
//   arb_en_i   - arbitration allowed this cycle (idle, or current transfer acking)
//   if_req_i   - fetch request level
//   mem_req_i  - data-port request level (read or write)
//   mask_if_i  - fetch was just served; its request line is stale this cycle
//   starve_i   - consecutive data grants issued while fetch waited
//   gnt_if_o   - grant fetch on this edge
//   gnt_mem_o  - grant data port on this edge
module mc_prio_sel
    import mc_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int CNT_W      = starve_w(STARVE_LIM)
) (
    input  logic             arb_en_i,
    input  logic             if_req_i,
    input  logic             mem_req_i,
    input  logic             mask_if_i,
    input  logic [CNT_W-1:0] starve_i,
    output logic             gnt_if_o,
    output logic             gnt_mem_o
);
    logic if_v;
    logic mem_v;
    logic starved;

    // Fetch holds its line until it sees done, so on its own ack edge the line
    // is stale and must be masked. A data line is a plain level: if it is still
    // high it is a fresh request, bounded against fetch by the starvation limit.
    assign if_v      = arb_en_i & if_req_i & ~mask_if_i;
    assign mem_v     = arb_en_i & mem_req_i;
    assign starved   = if_v & (starve_i == CNT_W'(STARVE_LIM));
    assign gnt_if_o  = if_v & (~mem_v | starved);
    assign gnt_mem_o = mem_v & ~gnt_if_o;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) arbiter in front of one memory port.
// Ports:
//   clock, reset                    - clock, asynchronous active-low reset
//   if_mc_en, if_mc_addr            - fetch read request (held until done) and address
//   mc_if_data, mc_if_done          - fetch read data, one-cycle completion pulse
//   mem_mc_read/write/addr/wdata    - data-port request levels, address, write data
//   mc_mem_data, mc_mem_done        - data-port read data, one-cycle completion pulse
//   mc_ram_req/we/addr/wdata        - memory request (held until ack) and its fields
//   ram_mc_ack, ram_mc_data         - memory completion and read data
// All outputs come straight from registers.
module mem_arbiter
    import mc_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_mc_en,
    input  logic [ADDR_W-1:0] if_mc_addr,
    output logic [31:0]       mc_if_data,
    output logic              mc_if_done,
    input  logic              mem_mc_read,
    input  logic              mem_mc_write,
    input  logic [ADDR_W-1:0] mem_mc_addr,
    input  logic [31:0]       mem_mc_wdata,
    output logic [31:0]       mc_mem_data,
    output logic              mc_mem_done,
    output logic              mc_ram_req,
    output logic              mc_ram_we,
    output logic [ADDR_W-1:0] mc_ram_addr,
    output logic [31:0]       mc_ram_wdata,
    input  logic              ram_mc_ack,
    input  logic [31:0]       ram_mc_data
);
    localparam int CNT_W = starve_w(STARVE_LIM);

    mc_state_e         state_q;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_data_q;
    logic [31:0]       mem_data_q;
    logic              if_done_q;
    logic              mem_done_q;
    logic              ack_hit;
    logic              gnt_if;
    logic              gnt_mem;

    // Ack only counts while a transfer is outstanding; outside a grant state
    // mc_ram_req is low and a stray ack is dropped.
    assign ack_hit = ram_mc_ack & (state_q != IDLE);

    mc_prio_sel #(
        .STARVE_LIM (STARVE_LIM),
        .CNT_W      (CNT_W)
    ) u_prio_sel (
        .arb_en_i  ((state_q == IDLE) | ack_hit),
        .if_req_i  (if_mc_en),
        .mem_req_i (mem_mc_read | mem_mc_write),
        .mask_if_i (ack_hit & (state_q == GNT_IF)),
        .starve_i  (starve_q),
        .gnt_if_o  (gnt_if),
        .gnt_mem_o (gnt_mem)
    );

    assign starve_d = gnt_if ? '0 :
                      (gnt_mem & if_mc_en & (starve_q != CNT_W'(STARVE_LIM))) ? starve_q + 1'b1 :
                      starve_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            mem_data_q <= '0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            starve_q   <= starve_d;
            if (ack_hit) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
                if (state_q == GNT_IF) begin
                    if_done_q <= 1'b1;
                    if_data_q <= ram_mc_data;
                end else begin
                    mem_done_q <= 1'b1;
                    if (!we_q) mem_data_q <= ram_mc_data;
                end
            end
            // A grant on the ack edge overrides the drop above, giving
            // back-to-back transfers with no idle cycle.
            if (gnt_if || gnt_mem) begin
                state_q <= gnt_if ? GNT_IF : GNT_MEM;
                req_q   <= 1'b1;
                we_q    <= gnt_mem & mem_mc_write;
                addr_q  <= gnt_if ? if_mc_addr : mem_mc_addr;
                if (gnt_mem) wdata_q <= mem_mc_wdata;
            end
        end
    end

    assign mc_ram_req   = req_q;
    assign mc_ram_we    = we_q;
    assign mc_ram_addr  = addr_q;
    assign mc_ram_wdata = wdata_q;
    assign mc_if_data   = if_data_q;
    assign mc_if_done   = if_done_q;
    assign mc_mem_data  = mem_data_q;
    assign mc_mem_done  = mem_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (vectors, corner sequences, random vs model).
module tb_mem_arbiter;
    localparam int AW  = 18;
    localparam int LIM = 3;

    logic          clock;
    logic          reset;
    logic          if_mc_en;
    logic [AW-1:0] if_mc_addr;
    logic [31:0]   mc_if_data;
    logic          mc_if_done;
    logic          mem_mc_read;
    logic          mem_mc_write;
    logic [AW-1:0] mem_mc_addr;
    logic [31:0]   mem_mc_wdata;
    logic [31:0]   mc_mem_data;
    logic          mc_mem_done;
    logic          mc_ram_req;
    logic          mc_ram_we;
    logic [AW-1:0] mc_ram_addr;
    logic [31:0]   mc_ram_wdata;
    logic          ram_mc_ack;
    logic [31:0]   ram_mc_data;

    int n_run;
    int n_fail;

    mem_arbiter #(.ADDR_W(AW), .STARVE_LIM(LIM)) dut (
        .clock        (clock),
        .reset        (reset),
        .if_mc_en     (if_mc_en),
        .if_mc_addr   (if_mc_addr),
        .mc_if_data   (mc_if_data),
        .mc_if_done   (mc_if_done),
        .mem_mc_read  (mem_mc_read),
        .mem_mc_write (mem_mc_write),
        .mem_mc_addr  (mem_mc_addr),
        .mem_mc_wdata (mem_mc_wdata),
        .mc_mem_data  (mc_mem_data),
        .mc_mem_done  (mc_mem_done),
        .mc_ram_req   (mc_ram_req),
        .mc_ram_we    (mc_ram_we),
        .mc_ram_addr  (mc_ram_addr),
        .mc_ram_wdata (mc_ram_wdata),
        .ram_mc_ack   (ram_mc_ack),
        .ram_mc_data  (ram_mc_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_mc_en     = 1'b0;
        if_mc_addr   = '0;
        mem_mc_read  = 1'b0;
        mem_mc_write = 1'b0;
        mem_mc_addr  = '0;
        mem_mc_wdata = '0;
        ram_mc_ack   = 1'b0;
        ram_mc_data  = '0;
    endtask

    // single-transaction vectors
    typedef struct {
        bit          f;
        bit          rd;
        bit          wr;
        logic [17:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          lat;
        bit          e_we;
        logic [31:0] e_if;
        logic [31:0] e_mem;
    } vec_t;

    vec_t tbl[6];

    // behavioural reference: who owns the memory port, how long fetch has been passed over
    int          m_owner;
    int          m_starve;
    logic        m_req;
    logic        m_we;
    logic [17:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_if_data;
    logic [31:0] m_mem_data;
    logic        m_if_done;
    logic        m_mem_done;

    task automatic model_edge();
        int served;
        bit want_f;
        bit want_d;
        served     = 0;
        m_if_done  = 1'b0;
        m_mem_done = 1'b0;
        if (m_owner != 0 && ram_mc_ack) begin
            if (m_owner == 1) begin
                m_if_done = 1'b1;
                m_if_data = ram_mc_data;
            end else begin
                m_mem_done = 1'b1;
                if (!m_we) m_mem_data = ram_mc_data;
            end
            served  = m_owner;
            m_owner = 0;
            m_req   = 1'b0;
        end
        if (m_owner == 0) begin
            want_f = if_mc_en && served != 1;
            want_d = mem_mc_read || mem_mc_write;
            if (want_f && (!want_d || m_starve == LIM)) begin
                m_owner  = 1;
                m_starve = 0;
                m_req    = 1'b1;
                m_we     = 1'b0;
                m_addr   = if_mc_addr;
            end else if (want_d) begin
                m_owner = 2;
                if (if_mc_en && m_starve < LIM) m_starve = m_starve + 1;
                m_req   = 1'b1;
                m_we    = mem_mc_write;
                m_addr  = mem_mc_addr;
                m_wdata = mem_mc_wdata;
            end
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        idle_inputs();
        reset = 1'b0;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 18'h00010, 32'h0,        32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 18'h00123, 32'h0,        32'hA5A50001, 0, 1'b0, 32'hDEADBEEF, 32'hA5A50001};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 18'h00200, 32'hCAFEF00D, 32'h11111111, 1, 1'b1, 32'hDEADBEEF, 32'hA5A50001};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 18'h3FFFF, 32'h12345678, 32'h99999999, 0, 1'b1, 32'hDEADBEEF, 32'hA5A50001};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 18'h3FFFF, 32'h0,        32'h0BADF00D, 3, 1'b0, 32'h0BADF00D, 32'hA5A50001};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 18'h00000, 32'h0,        32'hFFFFFFFF, 1, 1'b0, 32'h0BADF00D, 32'hFFFFFFFF};

        // reset state
        cyc();
        cyc();
        chk("rst_req", mc_ram_req, 0);
        chk("rst_we", mc_ram_we, 0);
        chk("rst_addr", mc_ram_addr, 0);
        chk("rst_wdata", mc_ram_wdata, 0);
        chk("rst_if_data", mc_if_data, 0);
        chk("rst_if_done", mc_if_done, 0);
        chk("rst_mem_data", mc_mem_data, 0);
        chk("rst_mem_done", mc_mem_done, 0);
        reset = 1'b1;
        cyc();

        // vector table: one transaction per row
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].f) begin
                if_mc_en   = 1'b1;
                if_mc_addr = tbl[i].a;
            end else begin
                mem_mc_read  = tbl[i].rd;
                mem_mc_write = tbl[i].wr;
                mem_mc_addr  = tbl[i].a;
                mem_mc_wdata = tbl[i].wd;
            end
            cyc();
            chk("vec_req", mc_ram_req, 1);
            chk("vec_we", mc_ram_we, tbl[i].e_we);
            chk("vec_addr", mc_ram_addr, tbl[i].a);
            if (!tbl[i].f) begin
                chk("vec_wdata", mc_ram_wdata, tbl[i].wd);
                mem_mc_read  = 1'b0;
                mem_mc_write = 1'b0;
                mem_mc_addr  = ~tbl[i].a;
                mem_mc_wdata = ~tbl[i].wd;
            end
            for (int k = 0; k < tbl[i].lat; k++) begin
                cyc();
                chk("vec_wait_done", {mc_if_done, mc_mem_done}, 0);
            end
            chk("vec_addr_held", mc_ram_addr, tbl[i].a);
            ram_mc_ack  = 1'b1;
            ram_mc_data = tbl[i].rdat;
            cyc();
            ram_mc_ack = 1'b0;
            chk("vec_if_done", mc_if_done, tbl[i].f);
            chk("vec_mem_done", mc_mem_done, !tbl[i].f);
            chk("vec_if_data", mc_if_data, tbl[i].e_if);
            chk("vec_mem_data", mc_mem_data, tbl[i].e_mem);
            if_mc_en = 1'b0;
            cyc();
            chk("vec_done_pulse", {mc_if_done, mc_mem_done}, 0);
            chk("vec_req_drop", mc_ram_req, 0);
        end

        // address change during a grant is ignored
        mem_mc_read = 1'b1;
        mem_mc_addr = 18'h00004;
        cyc();
        chk("hold_first", mc_ram_addr, 18'h00004);
        mem_mc_read = 1'b0;
        mem_mc_addr = 18'h00008;
        cyc();
        chk("hold_w1", mc_ram_addr, 18'h00004);
        cyc();
        chk("hold_w2", mc_ram_addr, 18'h00004);
        ram_mc_ack  = 1'b1;
        ram_mc_data = 32'h44444444;
        cyc();
        ram_mc_ack = 1'b0;
        chk("hold_done", mc_mem_done, 1);
        chk("hold_data", mc_mem_data, 32'h44444444);
        cyc();

        // simultaneous fetch + read, zero-wait memory: D then F back to back
        if_mc_en    = 1'b1;
        if_mc_addr  = 18'h00040;
        mem_mc_read = 1'b1;
        mem_mc_addr = 18'h00080;
        ram_mc_ack  = 1'b1;
        ram_mc_data = 32'h5555AAAA;
        cyc();
        chk("b2b_first_addr", mc_ram_addr, 18'h00080);
        mem_mc_read = 1'b0;
        cyc();
        chk("b2b_mem_done", mc_mem_done, 1);
        chk("b2b_if_done_early", mc_if_done, 0);
        chk("b2b_no_idle", mc_ram_req, 1);
        chk("b2b_second_addr", mc_ram_addr, 18'h00040);
        chk("b2b_mem_data", mc_mem_data, 32'h5555AAAA);
        ram_mc_data = 32'h6666BBBB;
        cyc();
        chk("b2b_if_done", mc_if_done, 1);
        chk("b2b_mem_done_pulse", mc_mem_done, 0);
        chk("b2b_if_data", mc_if_data, 32'h6666BBBB);
        if_mc_en   = 1'b0;
        ram_mc_ack = 1'b0;
        cyc();
        chk("b2b_req_drop", mc_ram_req, 0);

        // starvation: fetch held, data continuous -> D,D,D,F,D,D,D,F
        begin
            logic [17:0] order [8];
            order = '{18'h200, 18'h200, 18'h200, 18'h100, 18'h200, 18'h200, 18'h200, 18'h100};
            if_mc_en    = 1'b1;
            if_mc_addr  = 18'h00100;
            mem_mc_read = 1'b1;
            mem_mc_addr = 18'h00200;
            ram_mc_ack  = 1'b1;
            ram_mc_data = 32'h77777777;
            for (int i = 0; i < 8; i++) begin
                cyc();
                chk("starve_order", mc_ram_addr, order[i]);
            end
            if_mc_en    = 1'b0;
            mem_mc_read = 1'b0;
            cyc();
            chk("starve_last_if_done", mc_if_done, 1);
            ram_mc_ack = 1'b0;
            cyc();
            chk("starve_idle", mc_ram_req, 0);
        end

        // reset while a transfer waits for ack
        mem_mc_read = 1'b1;
        mem_mc_addr = 18'h0ABCD;
        cyc();
        chk("rip_req_up", mc_ram_req, 1);
        mem_mc_read = 1'b0;
        cyc();
        reset = 1'b0;
        #1;
        chk("rip_req_async", mc_ram_req, 0);
        chk("rip_addr", mc_ram_addr, 0);
        chk("rip_mem_data", mc_mem_data, 0);
        chk("rip_if_data", mc_if_data, 0);
        #2;
        reset = 1'b1;
        ram_mc_ack  = 1'b1;
        ram_mc_data = 32'h12121212;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rip_no_done", {mc_if_done, mc_mem_done}, 0);
            chk("rip_req_low", mc_ram_req, 0);
        end
        chk("rip_data_zero", mc_mem_data, 0);
        ram_mc_ack = 1'b0;

        // random traffic against the reference model
        idle_inputs();
        reset = 1'b0;
        #1;
        reset      = 1'b1;
        m_owner    = 0;
        m_starve   = 0;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_if_data  = '0;
        m_mem_data = '0;
        m_if_done  = 1'b0;
        m_mem_done = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (mc_if_done) if_mc_en = 1'b0;
            else if (!if_mc_en && $urandom_range(0, 2) == 0) begin
                if_mc_en   = 1'b1;
                if_mc_addr = 18'($urandom);
            end
            mem_mc_read  = $urandom_range(0, 2) == 0;
            mem_mc_write = $urandom_range(0, 3) == 0;
            mem_mc_addr  = 18'($urandom);
            mem_mc_wdata = $urandom;
            ram_mc_ack   = $urandom_range(0, 2) != 0;
            ram_mc_data  = $urandom;
            @(posedge clock);
            model_edge();
            #1;
            chk("rnd_req", mc_ram_req, m_req);
            chk("rnd_we", mc_ram_we, m_we);
            chk("rnd_addr", mc_ram_addr, m_addr);
            chk("rnd_wdata", mc_ram_wdata, m_wdata);
            chk("rnd_if_data", mc_if_data, m_if_data);
            chk("rnd_if_done", mc_if_done, m_if_done);
            chk("rnd_mem_data", mc_mem_data, m_mem_data);
            chk("rnd_mem_done", mc_mem_done, m_mem_done);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
